raster_ray_scanner: RTL and testbench

- Primary-ray source that sits directly upstream of the raster ray generator.
- On a start pulse it latches camera parameters, then walks every pixel of the screen.
- It builds each pixel's un-normalised ray direction incrementally in Q16.16 fixed point and pushes one ray per handshake into the generator's single-entry input buffer.
- It honours that buffer's fifo_full back-pressure and signals frame completion.

---
 rtl/raster_ray_scanner.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_raster_ray_scanner.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_ray_scanner.sv
`default_nettype none
// ============================================================================
// Module   : raster_ray_scanner
// Purpose  : Primary-ray source. It walks the screen and pushes one Q16.16 ray per handshake.
//            Tiled visiting order is available when RAY_SCAN_TILE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module raster_ray_scanner #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int TILE_W   = 8,
    parameter int TILE_H   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] cam_orig_x,
    input  logic [31:0] cam_orig_y,
    input  logic [31:0] cam_orig_z,
    input  logic [31:0] cam_dir0_x,
    input  logic [31:0] cam_dir0_y,
    input  logic [31:0] cam_dir0_z,
    input  logic [31:0] cam_du_x,
    input  logic [31:0] cam_du_y,
    input  logic [31:0] cam_du_z,
    input  logic [31:0] cam_dv_x,
    input  logic [31:0] cam_dv_y,
    input  logic [31:0] cam_dv_z,
    input  logic        fifo_full,
    output logic        add_input,
    output logic [31:0] ray_orig_x,
    output logic [31:0] ray_orig_y,
    output logic [31:0] ray_orig_z,
    output logic [31:0] ray_dir_x,
    output logic [31:0] ray_dir_y,
    output logic [31:0] ray_dir_z,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        busy,
    output logic        done
);

    localparam logic [11:0] c_last_x = 12'(SCREEN_W - 1);
    localparam logic [11:0] c_last_y = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state;

    // Axis index 0 = x, 1 = y, 2 = z.
    logic [2:0][31:0] w_cam_orig;
    logic [2:0][31:0] w_cam_dir0;
    logic [2:0][31:0] w_cam_du;
    logic [2:0][31:0] w_cam_dv;

    logic [2:0][31:0] r_orig, w_orig;
    logic [2:0][31:0] r_du, w_du;
    logic [2:0][31:0] r_dv, w_dv;
    logic [2:0][31:0] r_cur, w_cur;
    logic [2:0][31:0] r_row, w_row;
    logic [2:0][31:0] r_ray_orig, w_ray_orig;
    logic [2:0][31:0] r_ray_dir, w_ray_dir;
    logic [11:0]      r_x, w_x;
    logic [11:0]      r_y, w_y;
    logic [11:0]      r_pix_x, w_pix_x;
    logic [11:0]      r_pix_y, w_pix_y;
    logic             r_add, w_add;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             w_last;

`ifdef RAY_SCAN_TILE_EN
    localparam int          c_tw_log2     = $clog2(TILE_W);
    localparam int          c_th_log2     = $clog2(TILE_H);
    localparam logic [11:0] c_tile_last_x = 12'(TILE_W - 1);
    localparam logic [11:0] c_tile_last_y = 12'(TILE_H - 1);

    logic [2:0][31:0] r_tile, w_tile;
    logic [2:0][31:0] r_trow, w_trow;
    logic [11:0]      r_tx, w_tx;
    logic [11:0]      r_ty, w_ty;
`endif

    generate
        if (SCREEN_W < 2 || SCREEN_W > 4096 || SCREEN_H < 2 || SCREEN_H > 4096 ||
            TILE_W < 1 || (TILE_W & (TILE_W - 1)) != 0 ||
            TILE_H < 1 || (TILE_H & (TILE_H - 1)) != 0) begin : g_bad_params
            $error("raster_ray_scanner: illegal screen or tile parameters");
        end
`ifdef RAY_SCAN_TILE_EN
        if ((SCREEN_W % TILE_W) != 0 || (SCREEN_H % TILE_H) != 0) begin : g_bad_tile
            $error("raster_ray_scanner: tile size must divide the screen");
        end
`endif
    endgenerate

    assign w_cam_orig = {cam_orig_z, cam_orig_y, cam_orig_x};
    assign w_cam_dir0 = {cam_dir0_z, cam_dir0_y, cam_dir0_x};
    assign w_cam_du   = {cam_du_z, cam_du_y, cam_du_x};
    assign w_cam_dv   = {cam_dv_z, cam_dv_y, cam_dv_x};

    assign w_last = (r_x == c_last_x) && (r_y == c_last_y);

    always_comb begin
        w_state    = r_state;
        w_orig     = r_orig;
        w_du       = r_du;
        w_dv       = r_dv;
        w_cur      = r_cur;
        w_row      = r_row;
        w_ray_orig = r_ray_orig;
        w_ray_dir  = r_ray_dir;
        w_x        = r_x;
        w_y        = r_y;
        w_pix_x    = r_pix_x;
        w_pix_y    = r_pix_y;
        w_add      = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
`ifdef RAY_SCAN_TILE_EN
        w_tile     = r_tile;
        w_trow     = r_trow;
        w_tx       = r_tx;
        w_ty       = r_ty;
`endif

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_orig  = w_cam_orig;
                    w_du    = w_cam_du;
                    w_dv    = w_cam_dv;
                    w_cur   = w_cam_dir0;
                    w_row   = w_cam_dir0;
                    w_x     = 12'd0;
                    w_y     = 12'd0;
                    w_busy  = 1'b1;
`ifdef RAY_SCAN_TILE_EN
                    w_tile  = w_cam_dir0;
                    w_trow  = w_cam_dir0;
                    w_tx    = 12'd0;
                    w_ty    = 12'd0;
`endif
                    w_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!fifo_full) begin
                    w_add      = 1'b1;
                    w_ray_dir  = r_cur;
                    w_ray_orig = r_orig;
                    w_pix_x    = r_x;
                    w_pix_y    = r_y;
                    w_state    = ST_HOLD;
                end
            end

            ST_HOLD: begin
`ifdef RAY_SCAN_TILE_EN
                if (r_tx != c_tile_last_x) begin
                    w_tx = r_tx + 12'd1;
                    w_x  = r_x + 12'd1;
                    for (int a = 0; a < 3; a++) w_cur[a] = r_cur[a] + r_du[a];
                end else if (r_ty != c_tile_last_y) begin
                    w_tx = 12'd0;
                    w_ty = r_ty + 12'd1;
                    w_x  = r_x - c_tile_last_x;
                    w_y  = r_y + 12'd1;
                    for (int a = 0; a < 3; a++) begin
                        w_row[a] = r_row[a] + r_dv[a];
                        w_cur[a] = r_row[a] + r_dv[a];
                    end
                end else if (r_x != c_last_x) begin
                    // Step right to the next tile in the same tile row.
                    w_tx = 12'd0;
                    w_ty = 12'd0;
                    w_x  = r_x + 12'd1;
                    w_y  = r_y - c_tile_last_y;
                    for (int a = 0; a < 3; a++) begin
                        w_tile[a] = r_tile[a] + (r_du[a] << c_tw_log2);
                        w_row[a]  = r_tile[a] + (r_du[a] << c_tw_log2);
                        w_cur[a]  = r_tile[a] + (r_du[a] << c_tw_log2);
                    end
                end else begin
                    w_tx = 12'd0;
                    w_ty = 12'd0;
                    w_x  = 12'd0;
                    w_y  = r_y + 12'd1;
                    for (int a = 0; a < 3; a++) begin
                        w_trow[a] = r_trow[a] + (r_dv[a] << c_th_log2);
                        w_tile[a] = r_trow[a] + (r_dv[a] << c_th_log2);
                        w_row[a]  = r_trow[a] + (r_dv[a] << c_th_log2);
                        w_cur[a]  = r_trow[a] + (r_dv[a] << c_th_log2);
                    end
                end
`else
                if (r_x != c_last_x) begin
                    w_x = r_x + 12'd1;
                    for (int a = 0; a < 3; a++) w_cur[a] = r_cur[a] + r_du[a];
                end else begin
                    w_x = 12'd0;
                    w_y = r_y + 12'd1;
                    for (int a = 0; a < 3; a++) begin
                        w_row[a] = r_row[a] + r_dv[a];
                        w_cur[a] = r_row[a] + r_dv[a];
                    end
                end
`endif
                w_state = w_last ? ST_DONE : ST_ISSUE;
            end

            ST_DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end

            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_orig     <= '0;
            r_du       <= '0;
            r_dv       <= '0;
            r_cur      <= '0;
            r_row      <= '0;
            r_ray_orig <= '0;
            r_ray_dir  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_add      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef RAY_SCAN_TILE_EN
            r_tile     <= '0;
            r_trow     <= '0;
            r_tx       <= '0;
            r_ty       <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_orig     <= w_orig;
            r_du       <= w_du;
            r_dv       <= w_dv;
            r_cur      <= w_cur;
            r_row      <= w_row;
            r_ray_orig <= w_ray_orig;
            r_ray_dir  <= w_ray_dir;
            r_x        <= w_x;
            r_y        <= w_y;
            r_pix_x    <= w_pix_x;
            r_pix_y    <= w_pix_y;
            r_add      <= w_add;
            r_busy     <= w_busy;
            r_done     <= w_done;
`ifdef RAY_SCAN_TILE_EN
            r_tile     <= w_tile;
            r_trow     <= w_trow;
            r_tx       <= w_tx;
            r_ty       <= w_ty;
`endif
        end
    end

    assign add_input  = r_add;
    assign ray_orig_x = r_ray_orig[0];
    assign ray_orig_y = r_ray_orig[1];
    assign ray_orig_z = r_ray_orig[2];
    assign ray_dir_x  = r_ray_dir[0];
    assign ray_dir_y  = r_ray_dir[1];
    assign ray_dir_z  = r_ray_dir[2];
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_raster_ray_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_ray_scanner
// Purpose  : Self-checking bench for raster_ray_scanner against a pixel-order/direction model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_raster_ray_scanner;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TW = 2;
    localparam int TH = 2;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        fifo_full = 1'b0;
    logic [31:0] cam_orig_x = '0, cam_orig_y = '0, cam_orig_z = '0;
    logic [31:0] cam_dir0_x = '0, cam_dir0_y = '0, cam_dir0_z = '0;
    logic [31:0] cam_du_x = '0, cam_du_y = '0, cam_du_z = '0;
    logic [31:0] cam_dv_x = '0, cam_dv_y = '0, cam_dv_z = '0;
    logic        add_input;
    logic [31:0] ray_orig_x, ray_orig_y, ray_orig_z;
    logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
    logic [11:0] pix_x, pix_y;
    logic        busy, done;

    always #5 clk = ~clk;

    raster_ray_scanner #(
        .SCREEN_W(W), .SCREEN_H(H), .TILE_W(TW), .TILE_H(TH)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .cam_orig_x(cam_orig_x), .cam_orig_y(cam_orig_y), .cam_orig_z(cam_orig_z),
        .cam_dir0_x(cam_dir0_x), .cam_dir0_y(cam_dir0_y), .cam_dir0_z(cam_dir0_z),
        .cam_du_x(cam_du_x), .cam_du_y(cam_du_y), .cam_du_z(cam_du_z),
        .cam_dv_x(cam_dv_x), .cam_dv_y(cam_dv_y), .cam_dv_z(cam_dv_z),
        .fifo_full(fifo_full), .add_input(add_input),
        .ray_orig_x(ray_orig_x), .ray_orig_y(ray_orig_y), .ray_orig_z(ray_orig_z),
        .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
        .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done)
    );

    typedef struct {
        int          x;
        int          y;
        logic [31:0] dx, dy, dz, ox, oy, oz;
    } ray_t;

    ray_t        obs_q[$];
    int          ord_x[$];
    int          ord_y[$];
    logic [31:0] e_o[3], e_d0[3], e_du[3], e_dv[3];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_push = -1;
    int          min_gap = 1000;
    int          max_gap = 0;
    int          done_cnt = 0;

    // Passive monitor: records every pushed ray and done pulse.
    always @(negedge clk) begin
        cyc++;
        if (add_input === 1'b1) begin
            obs_q.push_back('{int'(pix_x), int'(pix_y), ray_dir_x, ray_dir_y, ray_dir_z,
                              ray_orig_x, ray_orig_y, ray_orig_z});
            if (last_push >= 0) begin
                if (cyc - last_push < min_gap) min_gap = cyc - last_push;
                if (cyc - last_push > max_gap) max_gap = cyc - last_push;
            end
            last_push = cyc;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected pixel visiting order.
    task automatic build_order();
        ord_x.delete();
        ord_y.delete();
`ifdef RAY_SCAN_TILE_EN
        for (int by = 0; by < H; by += TH)
            for (int bx = 0; bx < W; bx += TW)
                for (int yy = 0; yy < TH; yy++)
                    for (int xx = 0; xx < TW; xx++) begin
                        ord_x.push_back(bx + xx);
                        ord_y.push_back(by + yy);
                    end
`else
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                ord_x.push_back(xx);
                ord_y.push_back(yy);
            end
`endif
    endtask

    function automatic logic [31:0] exp_dir(input int a, input int px, input int py);
        return e_d0[a] + e_du[a] * 32'(px) + e_dv[a] * 32'(py);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt  = 0;
        last_push = -1;
        min_gap   = 1000;
        max_gap   = 0;
    endtask

    task automatic random_cam();
        for (int a = 0; a < 3; a++) begin
            e_o[a]  = $urandom;
            e_d0[a] = $urandom;
            e_du[a] = $urandom;
            e_dv[a] = $urandom;
        end
    endtask

    task automatic apply_cam();
        {cam_orig_x, cam_orig_y, cam_orig_z} = {e_o[0], e_o[1], e_o[2]};
        {cam_dir0_x, cam_dir0_y, cam_dir0_z} = {e_d0[0], e_d0[1], e_d0[2]};
        {cam_du_x, cam_du_y, cam_du_z}       = {e_du[0], e_du[1], e_du[2]};
        {cam_dv_x, cam_dv_y, cam_dv_z}       = {e_dv[0], e_dv[1], e_dv[2]};
    endtask

    task automatic scramble_ports();
        {cam_orig_x, cam_orig_y, cam_orig_z} = {$urandom, $urandom, $urandom};
        {cam_dir0_x, cam_dir0_y, cam_dir0_z} = {$urandom, $urandom, $urandom};
        {cam_du_x, cam_du_y, cam_du_z}       = {$urandom, $urandom, $urandom};
        {cam_dv_x, cam_dv_y, cam_dv_z}       = {$urandom, $urandom, $urandom};
    endtask

    task automatic start_frame();
        clear_obs();
        apply_cam();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_pushes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (add_input !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got add/busy/done=%b%b%b, expected 000", add_input, busy, done);
        end
        checks++;
        if (pix_x !== 12'd0 || pix_y !== 12'd0) begin
            failures++;
            $display("FAIL reset_pix: got (%0d,%0d), expected (0,0)", pix_x, pix_y);
        end
        checks++;
        if ({ray_dir_x, ray_dir_y, ray_dir_z, ray_orig_x, ray_orig_y, ray_orig_z} !== '0) begin
            failures++;
            $display("FAIL reset_ray: got dir=%h/%h/%h orig=%h/%h/%h, expected all 0",
                     ray_dir_x, ray_dir_y, ray_dir_z, ray_orig_x, ray_orig_y, ray_orig_z);
        end
        resetn = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || add_input !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b add=%b, expected 0 0", busy, add_input);
        end
    endtask

    task automatic test_raster_directed();
        bit ok;
        int idx;
        for (int a = 0; a < 3; a++) e_o[a] = $urandom;
        e_d0[0] = 32'hFFFF0000; e_d0[1] = 32'h00010000; e_d0[2] = 32'h00010000;
        e_du[0] = 32'h00008000; e_du[1] = 32'h0;        e_du[2] = 32'h0;
        e_dv[0] = 32'h0;        e_dv[1] = 32'hFFFF8000; e_dv[2] = 32'h0;
        start_frame();
        checks++;
        if (add_input !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL latency_e0: got add=%b busy=%b, expected add=0 busy=1", add_input, busy);
        end
        step();
        checks++;
        if (add_input !== 1'b1 || pix_x !== 12'd0 || pix_y !== 12'd0) begin
            failures++;
            $display("FAIL latency_e1: got add=%b pix=(%0d,%0d), expected add=1 pix=(0,0)", add_input, pix_x, pix_y);
        end
        step();
        checks++;
        if (add_input !== 1'b0) begin
            failures++;
            $display("FAIL latency_e2: got add=%b, expected 0", add_input);
        end
        step();
        checks++;
        if (add_input !== 1'b1) begin
            failures++;
            $display("FAIL latency_e3: got add=%b, expected 1", add_input);
        end
        wait_done(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            failures++;
            $display("FAIL directed_done: got done_seen=%0d busy=%b, expected 1 and busy 0", ok, busy);
        end
        repeat (6) step();
        checks++;
        if (obs_q.size() != N || done_cnt != 1 || min_gap != 2 || max_gap != 2) begin
            failures++;
            $display("FAIL directed_frame: got pushes=%0d dones=%0d gap=%0d..%0d, expected %0d 1 2..2",
                     obs_q.size(), done_cnt, min_gap, max_gap, N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i]) ||
                obs_q[i].dz !== exp_dir(2, ord_x[i], ord_y[i]) ||
                obs_q[i].ox !== e_o[0] || obs_q[i].oy !== e_o[1] || obs_q[i].oz !== e_o[2]) begin
                failures++;
                $display("FAIL directed_ray[%0d]: got pix=(%0d,%0d) dir=%h/%h/%h, expected pix=(%0d,%0d) dir=%h/%h/%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dx, obs_q[i].dy, obs_q[i].dz, ord_x[i], ord_y[i],
                         exp_dir(0, ord_x[i], ord_y[i]), exp_dir(1, ord_x[i], ord_y[i]), exp_dir(2, ord_x[i], ord_y[i]));
            end
        end
        idx = -1;
        foreach (obs_q[i]) if (obs_q[i].x == 3 && obs_q[i].y == 1) idx = i;
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL pixel_3_1: got no push for (3,1), expected one");
        end else if (obs_q[idx].dx !== 32'h00008000 || obs_q[idx].dy !== 32'h00008000 || obs_q[idx].dz !== 32'h00010000) begin
            failures++;
            $display("FAIL pixel_3_1: got dir=%h/%h/%h, expected 00008000/00008000/00010000",
                     obs_q[idx].dx, obs_q[idx].dy, obs_q[idx].dz);
        end
    endtask

    task automatic test_raster_random();
        bit ok;
        for (int f = 0; f < 2; f++) begin
            random_cam();
            start_frame();
            wait_done(ok);
            repeat (4) step();
            checks++;
            if (!ok || obs_q.size() != N || done_cnt != 1) begin
                failures++;
                $display("FAIL random_frame%0d: got done_seen=%0d pushes=%0d dones=%0d, expected 1 %0d 1",
                         f, ok, obs_q.size(), done_cnt, N);
            end
            for (int i = 0; i < N && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                    obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i]) ||
                    obs_q[i].dz !== exp_dir(2, ord_x[i], ord_y[i]) ||
                    obs_q[i].ox !== e_o[0] || obs_q[i].oy !== e_o[1] || obs_q[i].oz !== e_o[2]) begin
                    failures++;
                    $display("FAIL random_ray[%0d]: got pix=(%0d,%0d) dir_x=%h orig_x=%h, expected pix=(%0d,%0d) dir_x=%h orig_x=%h",
                             i, obs_q[i].x, obs_q[i].y, obs_q[i].dx, obs_q[i].ox, ord_x[i], ord_y[i],
                             exp_dir(0, ord_x[i], ord_y[i]), e_o[0]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        random_cam();
        start_frame();
        wait_pushes(2, ok);
        fifo_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (add_input !== 1'b0) bad++;
        end
        fifo_full = 1'b0;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL stall_no_push: got reached=%0d pushes_during_stall=%0d, expected 1 0", ok, bad);
        end
        wait_done(ok);
        repeat (4) step();
        checks++;
        if (!ok || obs_q.size() != N || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_frame: got pushes=%0d dones=%0d, expected %0d 1", obs_q.size(), done_cnt, N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i]) ||
                obs_q[i].dz !== exp_dir(2, ord_x[i], ord_y[i])) begin
                failures++;
                $display("FAIL stall_ray[%0d]: got pix=(%0d,%0d) dir_x=%h, expected pix=(%0d,%0d) dir_x=%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dx, ord_x[i], ord_y[i], exp_dir(0, ord_x[i], ord_y[i]));
            end
        end
    endtask

    task automatic test_random_backpressure();
        random_cam();
        start_frame();
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            step();
        end
        fifo_full = 1'b0;
        repeat (4) step();
        checks++;
        if (done_cnt != 1 || obs_q.size() != N || min_gap < 2) begin
            failures++;
            $display("FAIL backpressure_frame: got dones=%0d pushes=%0d min_gap=%0d, expected 1 %0d >=2",
                     done_cnt, obs_q.size(), min_gap, N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i]) ||
                obs_q[i].dz !== exp_dir(2, ord_x[i], ord_y[i])) begin
                failures++;
                $display("FAIL backpressure_ray[%0d]: got pix=(%0d,%0d) dir_y=%h, expected pix=(%0d,%0d) dir_y=%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dy, ord_x[i], ord_y[i], exp_dir(1, ord_x[i], ord_y[i]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        random_cam();
        start_frame();
        wait_pushes(3, ok);
        scramble_ports();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            scramble_ports();
            step();
        end
        repeat (20) step();
        checks++;
        if (!ok || done_cnt != 1 || obs_q.size() != N) begin
            failures++;
            $display("FAIL busy_start_frame: got dones=%0d pushes=%0d, expected 1 %0d", done_cnt, obs_q.size(), N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i]) ||
                obs_q[i].dz !== exp_dir(2, ord_x[i], ord_y[i]) ||
                obs_q[i].ox !== e_o[0] || obs_q[i].oy !== e_o[1] || obs_q[i].oz !== e_o[2]) begin
                failures++;
                $display("FAIL busy_start_ray[%0d]: got pix=(%0d,%0d) dir_z=%h orig_z=%h, expected pix=(%0d,%0d) dir_z=%h orig_z=%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dz, obs_q[i].oz, ord_x[i], ord_y[i],
                         exp_dir(2, ord_x[i], ord_y[i]), e_o[2]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        random_cam();
        start_frame();
        wait_pushes(3, ok);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (!ok || add_input !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ray_dir_x !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got add/busy/done=%b%b%b dir_x=%h, expected 000 and 0",
                     add_input, busy, done, ray_dir_x);
        end
        repeat (3) step();
        resetn = 1'b1;
        repeat (10) step();
        checks++;
        if (obs_q.size() != 3 || busy !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got pushes=%0d busy=%b dones=%0d, expected 3 0 0", obs_q.size(), busy, done_cnt);
        end
        random_cam();
        start_frame();
        wait_done(ok);
        repeat (4) step();
        checks++;
        if (!ok || obs_q.size() != N || obs_q[0].x != 0 || obs_q[0].y != 0) begin
            failures++;
            $display("FAIL reset_restart: got pushes=%0d, first pix=(%0d,%0d), expected %0d and (0,0)",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].x : -1, obs_q.size() > 0 ? obs_q[0].y : -1, N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i] ||
                obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].dy !== exp_dir(1, ord_x[i], ord_y[i])) begin
                failures++;
                $display("FAIL reset_restart_ray[%0d]: got pix=(%0d,%0d) dir_x=%h, expected pix=(%0d,%0d) dir_x=%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dx, ord_x[i], ord_y[i], exp_dir(0, ord_x[i], ord_y[i]));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int idx;
        random_cam();
        e_d0[0] = 32'h7FFF0000;
        e_du[0] = 32'h00010000;
        start_frame();
        wait_done(ok);
        repeat (4) step();
        idx = -1;
        foreach (obs_q[i]) if (obs_q[i].x == 1 && obs_q[i].y == 0) idx = i;
        checks++;
        if (!ok || idx < 0) begin
            failures++;
            $display("FAIL wrap_pixel: got done_seen=%0d idx=%0d, expected a push for (1,0)", ok, idx);
        end else if (obs_q[idx].dx !== 32'h80000000) begin
            failures++;
            $display("FAIL wrap_pixel: got dir_x=%h, expected 80000000", obs_q[idx].dx);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].dx !== exp_dir(0, ord_x[i], ord_y[i]) || obs_q[i].x !== ord_x[i] || obs_q[i].y !== ord_y[i]) begin
                failures++;
                $display("FAIL wrap_ray[%0d]: got pix=(%0d,%0d) dir_x=%h, expected pix=(%0d,%0d) dir_x=%h",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].dx, ord_x[i], ord_y[i], exp_dir(0, ord_x[i], ord_y[i]));
            end
        end
    endtask

    initial begin
        build_order();
        test_reset();
        test_raster_directed();
        test_raster_random();
        test_stall();
        test_random_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
